// File: rtl/video_downscaler_nxm.sv
// video_downscaler_nxm: streaming SXxSY box-filter downscaler with frame lock and single output register
module video_downscaler_nxm #(
  parameter int D_WIDTH     = 8,
  parameter int CHANNELS    = 1,
  parameter int SCALE_X_LOG = 1,
  parameter int SCALE_Y_LOG = 1,
  parameter int LB_A_WIDTH  = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*D_WIDTH-1:0]  up_data,
  input  logic                         up_valid,
  input  logic                         up_tlast,
  input  logic                         up_tuser,
  output logic                         up_ready,
  output logic [CHANNELS*D_WIDTH-1:0]  down_data,
  output logic                         down_valid,
  output logic                         down_tlast,
  output logic                         down_tuser,
  input  logic                         down_ready,
  output logic                         locked,
  output logic                         line_err
);
  localparam int SX    = 1 << SCALE_X_LOG;
  localparam int SY    = 1 << SCALE_Y_LOG;
  localparam int SHIFT = SCALE_X_LOG + SCALE_Y_LOG;
  localparam int AW    = D_WIDTH + SHIFT;
  localparam int XW    = SCALE_X_LOG > 0 ? SCALE_X_LOG : 1;
  localparam int YW    = SCALE_Y_LOG > 0 ? SCALE_Y_LOG : 1;
  localparam int XOW   = LB_A_WIDTH + 1;
  typedef enum logic {UNLOCKED, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [XW-1:0] x_sub_q, x_sub_d, xs;
  logic [XOW-1:0] x_out_q, x_out_d, xo;
  logic [YW-1:0] y_sub_q, y_sub_d, ys;
  logic [CHANNELS*AW-1:0] hsum_q, hsum_d, hs_new, tot, lb_rdata;
  logic [CHANNELS*D_WIDTH-1:0] data_q, data_d, avg;
  logic row0_q, row0_d, ovf_q, ovf_d;
  logic valid_q, valid_d, tlast_q, tlast_d, tuser_q, tuser_d, err_q, err_d;
  logic take, in_range, x_end, y_end, complete, row0_eff, ovf_eff, lb_we;
  logic [CHANNELS*AW-1:0] lb [1 << LB_A_WIDTH];
  assign up_ready   = !valid_q | down_ready;
  assign take       = up_valid & up_ready & (up_tuser | (state_q == ACTIVE));
  // A tuser pixel is always x=0,y=0 of a fresh frame, so the effective position is forced to zero.
  assign xs         = up_tuser ? '0 : x_sub_q;
  assign xo         = up_tuser ? '0 : x_out_q;
  assign ys         = up_tuser ? '0 : y_sub_q;
  assign row0_eff   = up_tuser | row0_q;
  assign ovf_eff    = !up_tuser & ovf_q;
  assign in_range   = !xo[LB_A_WIDTH];
  assign x_end      = xs == XW'(SX - 1);
  assign y_end      = ys == YW'(SY - 1);
  assign complete   = x_end & in_range;
  assign lb_rdata   = lb[xo[LB_A_WIDTH-1:0]];
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign hs_new[c*AW +: AW]    = (xs == '0 ? '0 : hsum_q[c*AW +: AW]) + AW'(up_data[c*D_WIDTH +: D_WIDTH]);
    assign tot[c*AW +: AW]       = (ys == '0 ? '0 : lb_rdata[c*AW +: AW]) + hs_new[c*AW +: AW];
    assign avg[c*D_WIDTH +: D_WIDTH] = D_WIDTH'(tot[c*AW +: AW] >> SHIFT);
  end
  // Next state: counters advance per accepted pixel; a finished block row loads the output register.
  always_comb begin
    state_d = state_q;
    x_sub_d = x_sub_q;
    x_out_d = x_out_q;
    y_sub_d = y_sub_q;
    hsum_d  = hsum_q;
    row0_d  = row0_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    valid_d = valid_q & !down_ready;
    tlast_d = tlast_q;
    tuser_d = tuser_q;
    err_d   = 1'b0;
    lb_we   = 1'b0;
    if (take) begin
      state_d = ACTIVE;
      hsum_d  = hs_new;
      err_d   = (!in_range & !ovf_eff) | (up_tlast & in_range & !x_end);
      ovf_d   = (ovf_eff | !in_range) & !up_tlast;
      lb_we   = complete & !y_end;
      if (complete & y_end) begin
        valid_d = 1'b1;
        data_d  = avg;
        tlast_d = up_tlast;
        tuser_d = row0_eff & (xo == '0);
      end
      x_sub_d = (up_tlast | x_end) ? '0 : xs + XW'(1);
      x_out_d = up_tlast ? '0 : xo + XOW'(complete);
      y_sub_d = !up_tlast ? ys : y_end ? '0 : ys + YW'(1);
      row0_d  = row0_eff & !(up_tlast & y_end);
    end
  end
  // State and output registers; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNLOCKED;
      x_sub_q <= '0;
      x_out_q <= '0;
      y_sub_q <= '0;
      hsum_q  <= '0;
      row0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tlast_q <= 1'b0;
      tuser_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_sub_q <= x_sub_d;
      x_out_q <= x_out_d;
      y_sub_q <= y_sub_d;
      hsum_q  <= hsum_d;
      row0_q  <= row0_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tlast_q <= tlast_d;
      tuser_q <= tuser_d;
      err_q   <= err_d;
    end
  end
  // Line buffer of partial vertical sums; row 0 overwrites, so no clear is needed.
  always_ff @(posedge clk) begin
    if (lb_we) lb[xo[LB_A_WIDTH-1:0]] <= tot;
  end
  assign down_data  = data_q;
  assign down_valid = valid_q;
  assign down_tlast = tlast_q;
  assign down_tuser = tuser_q;
  assign locked     = state_q == ACTIVE;
  assign line_err   = err_q;
endmodule

// File: tb/tb_video_downscaler_nxm.sv
// tb_video_downscaler_nxm: directed self-checking bench for the 2x2/1ch and 4x2/3ch configurations
module tb_video_downscaler_nxm;
  logic clk = 0, rst = 0;
  logic [7:0] a_ud = '0;
  logic a_uv = 0, a_ul = 0, a_uu = 0, a_ur, a_dr = 1;
  logic [7:0] a_dd;
  logic a_dv, a_dl, a_du, a_lk, a_err;
  logic [23:0] b_ud = '0;
  logic b_uv = 0, b_ul = 0, b_uu = 0, b_ur, b_dr = 1;
  logic [23:0] b_dd;
  logic b_dv, b_dl, b_du, b_lk, b_err;
  logic [9:0] qa[$];
  logic [25:0] qb[$];
  int checks = 0, fails = 0, a_err_cnt = 0;

  video_downscaler_nxm dut_a (
    .clk(clk), .rst(rst), .up_data(a_ud), .up_valid(a_uv), .up_tlast(a_ul), .up_tuser(a_uu),
    .up_ready(a_ur), .down_data(a_dd), .down_valid(a_dv), .down_tlast(a_dl), .down_tuser(a_du),
    .down_ready(a_dr), .locked(a_lk), .line_err(a_err)
  );

  video_downscaler_nxm #(.CHANNELS(3), .SCALE_X_LOG(2), .SCALE_Y_LOG(1)) dut_b (
    .clk(clk), .rst(rst), .up_data(b_ud), .up_valid(b_uv), .up_tlast(b_ul), .up_tuser(b_uu),
    .up_ready(b_ur), .down_data(b_dd), .down_valid(b_dv), .down_tlast(b_dl), .down_tuser(b_du),
    .down_ready(b_dr), .locked(b_lk), .line_err(b_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_dv && a_dr) qa.push_back({a_du, a_dl, a_dd});
    if (b_dv && b_dr) qb.push_back({b_du, b_dl, b_dd});
    if (a_err) a_err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic push_a(input logic [7:0] d, input logic last, input logic user);
    int n = 0;
    a_ud = d; a_ul = last; a_uu = user; a_uv = 1;
    @(negedge clk);
    while (!a_ur && n < 1000) begin n++; @(negedge clk); end
    if (!a_ur) begin checks++; fails++; $display("FAIL push_a_timeout got ready=%b want 1", a_ur); end
    @(posedge clk); #1;
    a_uv = 0; a_ul = 0; a_uu = 0;
  endtask

  task automatic push_b(input logic [23:0] d, input logic last, input logic user);
    int n = 0;
    b_ud = d; b_ul = last; b_uu = user; b_uv = 1;
    @(negedge clk);
    while (!b_ur && n < 1000) begin n++; @(negedge clk); end
    if (!b_ur) begin checks++; fails++; $display("FAIL push_b_timeout got ready=%b want 1", b_ur); end
    @(posedge clk); #1;
    b_uv = 0; b_ul = 0; b_uu = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (a_dv !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", a_dv); end
    checks++; if (a_dd !== 8'd0) begin fails++; $display("FAIL reset_data got %0d want 0", a_dd); end
    checks++; if ({a_dl, a_du} !== 2'b00) begin fails++; $display("FAIL reset_tags got %b want 00", {a_dl, a_du}); end
    checks++; if ({a_lk, a_err} !== 2'b00) begin fails++; $display("FAIL reset_lock_err got %b want 00", {a_lk, a_err}); end
    checks++; if ({b_dv, b_lk} !== 2'b00) begin fails++; $display("FAIL reset_b got %b want 00", {b_dv, b_lk}); end
    @(posedge clk); #1 rst = 1;
  endtask

  task automatic test_prelock_basic;
    int e0 = a_err_cnt;
    qa.delete();
    for (int i = 0; i < 13; i++) push_a(8'(i * 7 + 3), i % 4 == 3, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (qa.size() != 0) begin fails++; $display("FAIL prelock_out got %0d outputs want 0", qa.size()); end
    checks++; if (a_lk !== 1'b0) begin fails++; $display("FAIL prelock_locked got %b want 0", a_lk); end
    checks++; if (a_err_cnt != e0) begin fails++; $display("FAIL prelock_err got %0d pulses want 0", a_err_cnt - e0); end
    push_a(8'd10, 0, 1);
    checks++; if (a_lk !== 1'b1) begin fails++; $display("FAIL lock_rise got %b want 1", a_lk); end
    push_a(8'd20, 0, 0); push_a(8'd30, 0, 0); push_a(8'd40, 1, 0);
    push_a(8'd30, 0, 0); push_a(8'd40, 0, 0); push_a(8'd50, 0, 0); push_a(8'd60, 1, 0);
    repeat (3) @(negedge clk);
    checks++; if (qa.size() != 2) begin fails++; $display("FAIL basic_count got %0d want 2", qa.size()); end
    checks++; if (qa[0] !== {1'b1, 1'b0, 8'd25}) begin fails++; $display("FAIL basic_px0 got %h want %h", qa[0], {1'b1, 1'b0, 8'd25}); end
    checks++; if (qa[1] !== {1'b0, 1'b1, 8'd45}) begin fails++; $display("FAIL basic_px1 got %h want %h", qa[1], {1'b0, 1'b1, 8'd45}); end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    qa.delete();
    a_dr = 0;
    push_a(8'd0, 0, 1); push_a(8'd100, 0, 0); push_a(8'd200, 0, 0); push_a(8'd255, 1, 0);
    push_a(8'd4, 0, 0); push_a(8'd8, 0, 0);
    fork
      begin push_a(8'd12, 0, 0); push_a(8'd16, 1, 0); end
      begin
        repeat (10) begin
          @(negedge clk);
          if (a_ur !== 1'b0 || a_dv !== 1'b1 || a_dd !== 8'd28 || a_du !== 1'b1) bad++;
        end
        @(posedge clk); #1 a_dr = 1;
      end
    join
    repeat (3) @(negedge clk);
    checks++; if (bad != 0) begin fails++; $display("FAIL stall_stable got %0d bad cycles want 0", bad); end
    checks++; if (qa.size() != 2) begin fails++; $display("FAIL bp_count got %0d want 2", qa.size()); end
    checks++; if (qa[0] !== {1'b1, 1'b0, 8'd28}) begin fails++; $display("FAIL bp_px0 got %h want %h", qa[0], {1'b1, 1'b0, 8'd28}); end
    checks++; if (qa[1] !== {1'b0, 1'b1, 8'd120}) begin fails++; $display("FAIL bp_px1 got %h want %h", qa[1], {1'b0, 1'b1, 8'd120}); end
  endtask

  task automatic test_malformed;
    int e0 = a_err_cnt;
    qa.delete();
    push_a(8'd10, 0, 1); push_a(8'd20, 0, 0); push_a(8'd30, 1, 0);
    checks++; if (a_err !== 1'b1) begin fails++; $display("FAIL malformed_pulse got %b want 1", a_err); end
    @(posedge clk); #1;
    checks++; if (a_err !== 1'b0) begin fails++; $display("FAIL malformed_pulse_end got %b want 0", a_err); end
    push_a(8'd50, 0, 0); push_a(8'd60, 1, 0);
    push_a(8'd1, 0, 0); push_a(8'd3, 1, 0); push_a(8'd5, 0, 0); push_a(8'd7, 1, 0);
    repeat (3) @(negedge clk);
    checks++; if (a_err_cnt - e0 != 1) begin fails++; $display("FAIL malformed_err_cnt got %0d want 1", a_err_cnt - e0); end
    checks++; if (qa.size() != 2) begin fails++; $display("FAIL malformed_count got %0d want 2", qa.size()); end
    checks++; if (qa[0] !== {1'b1, 1'b1, 8'd35}) begin fails++; $display("FAIL malformed_px0 got %h want %h", qa[0], {1'b1, 1'b1, 8'd35}); end
    checks++; if (qa[1] !== {1'b0, 1'b1, 8'd4}) begin fails++; $display("FAIL malformed_px1 got %h want %h", qa[1], {1'b0, 1'b1, 8'd4}); end
  endtask

  task automatic test_overlong;
    int e0 = a_err_cnt;
    qa.delete();
    for (int i = 0; i < 1026; i++) push_a(8'd4, i == 1025, i == 0);
    push_a(8'd8, 0, 0); push_a(8'd8, 1, 0);
    repeat (3) @(negedge clk);
    checks++; if (a_err_cnt - e0 != 1) begin fails++; $display("FAIL overlong_err_cnt got %0d want 1", a_err_cnt - e0); end
    checks++; if (qa.size() != 1) begin fails++; $display("FAIL overlong_count got %0d want 1", qa.size()); end
    checks++; if (qa[0] !== {1'b1, 1'b1, 8'd6}) begin fails++; $display("FAIL overlong_px got %h want %h", qa[0], {1'b1, 1'b1, 8'd6}); end
  endtask

  task automatic test_4x2_rgb;
    qb.delete();
    for (int i = 0; i < 8; i++) push_b(24'hFFFFFF, i % 4 == 3, i == 0);
    for (int i = 0; i < 4; i++) push_b(24'h010203, i == 3, i == 0);
    for (int i = 0; i < 8; i++) push_b({8'h00, 8'h80, 8'(i + 1)}, i % 4 == 3, i == 0);
    repeat (3) @(negedge clk);
    checks++; if (qb.size() != 2) begin fails++; $display("FAIL rgb_count got %0d want 2", qb.size()); end
    checks++; if (qb[0] !== {1'b1, 1'b1, 24'hFFFFFF}) begin fails++; $display("FAIL rgb_sat got %h want %h", qb[0], {1'b1, 1'b1, 24'hFFFFFF}); end
    checks++; if (qb[1] !== {1'b1, 1'b1, 24'h008004}) begin fails++; $display("FAIL rgb_restart got %h want %h", qb[1], {1'b1, 1'b1, 24'h008004}); end
  endtask

  task automatic test_reset_midline;
    qa.delete();
    a_dr = 0;
    push_a(8'd10, 0, 1); push_a(8'd20, 1, 0); push_a(8'd30, 0, 0); push_a(8'd40, 1, 0);
    checks++; if (a_dv !== 1'b1 || a_dd !== 8'd25) begin fails++; $display("FAIL pend_before_reset got v=%b d=%0d want v=1 d=25", a_dv, a_dd); end
    #3 rst = 0;
    #1;
    checks++; if ({a_dv, a_dl, a_du, a_lk} !== 4'b0000) begin fails++; $display("FAIL async_reset_flags got %b want 0000", {a_dv, a_dl, a_du, a_lk}); end
    checks++; if (a_dd !== 8'd0) begin fails++; $display("FAIL async_reset_data got %0d want 0", a_dd); end
    @(posedge clk); #1 rst = 1; a_dr = 1;
    qa.delete();
    push_a(8'd99, 0, 0); push_a(8'd99, 1, 0);
    push_a(8'd100, 0, 1); push_a(8'd200, 1, 0); push_a(8'd0, 0, 0); push_a(8'd4, 1, 0);
    repeat (3) @(negedge clk);
    checks++; if (qa.size() != 1) begin fails++; $display("FAIL relock_count got %0d want 1", qa.size()); end
    checks++; if (qa[0] !== {1'b1, 1'b1, 8'd76}) begin fails++; $display("FAIL relock_px got %h want %h", qa[0], {1'b1, 1'b1, 8'd76}); end
  endtask

  initial begin
    test_reset();
    test_prelock_basic();
    test_backpressure();
    test_malformed();
    test_overlong();
    test_4x2_rgb();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
